// File: rtl/lcd_msg_ctrl.sv
// HD44780-style 16x2 LCD message controller: on a START rising edge it clears the display, writes two text lines and holds them, then pulses DONE.
// Latency: BUSY rises the cycle after the edge; the power-on init runs only on the first message after reset; per-command timing comes from the parameters.
// Backpressure: none; START edges are ignored while BUSY. Optional feature macro LCD_AUTO_CLEAR_EN adds a Clear Display after the hold.
module lcd_msg_ctrl #(
    parameter int unsigned CLK_HZ   = 1_000_000,
    parameter int unsigned E_PULSE  = 1,
    parameter int unsigned EXEC_US  = 40,
    parameter int unsigned CLEAR_US = 1640,
    parameter int unsigned HOLD_MS  = 2000
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       START,
    input  logic [1:0] MSG_SEL,
    input  logic [3:0] LEVEL,
    output logic       TLCD_RS,
    output logic       TLCD_RW,
    output logic       TLCD_E,
    output logic [7:0] TLCD_DATA,
    output logic       BUSY,
    output logic       DONE,
    output logic       PASS
);

    localparam int unsigned EXEC_CYC  = (CLK_HZ / 1_000_000) * EXEC_US;
    localparam int unsigned CLEAR_CYC = (CLK_HZ / 1_000_000) * CLEAR_US;
    localparam int unsigned HOLD_CYC  = (CLK_HZ / 1_000) * HOLD_MS;

    // Last counter value of a command slot: setup cycle + E pulse + post-E wait.
    localparam logic [31:0] SLOT_LAST = 32'(E_PULSE + EXEC_CYC);
    localparam logic [31:0] CLR_LAST  = 32'(E_PULSE + CLEAR_CYC);
    // The hold window includes the FIN cycle, so HOLD itself lasts HOLD_CYC-1 cycles
    // (HOLD_CYC must be at least 2).
    localparam logic [31:0] HOLD_LAST = 32'(HOLD_CYC) - 32'd2;

    // Fixed 16-column line images; leftmost character in the top byte.
    localparam logic [127:0] TXT_S_L1 = "    SUCCESS     ";
    localparam logic [127:0] TXT_S_L2 = "    GOOD JOB    ";
    localparam logic [127:0] TXT_F_L1 = "      FAIL      ";
    localparam logic [127:0] TXT_F_L2 = "   TRY AGAIN    ";
    localparam logic [127:0] TXT_R_L1 = "     READY      ";
    localparam logic [127:0] TXT_R_L2 = "  PRESS START   ";
    localparam logic [127:0] TXT_L_L1 = "    LEVEL       ";
    localparam logic [127:0] TXT_L_L2 = "   KEEP GOING   ";

    typedef enum logic [3:0] {
        S_IDLE,
        S_FUNC,
        S_DISP,
        S_ENTRY,
        S_CLEAR,
        S_L1_ADDR,
        S_L1_CHAR,
        S_L2_ADDR,
        S_L2_CHAR,
        S_HOLD,
        S_END_CLR,
        S_FIN
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [4:0]  idx_q, idx_d;
    logic        start_q;
    logic        init_done_q, init_done_d;
    logic [1:0]  msg_q, msg_d;
    logic [3:0]  lvl_q, lvl_d;
    logic        pass_q, pass_d;

    logic        cmd;
    logic        slot_end;
    logic        rs_c;
    logic [7:0]  data_c;
    logic        e_c;
    logic        done_c;

    // Character at a given column of a given message line; LEVEL digit patched into column 10.
    function automatic logic [7:0] msg_char(input logic [1:0] msg, input logic line2,
                                            input logic [3:0] col, input logic [3:0] lvl);
        logic [127:0] row;
        logic [127:0] row_sh;
        logic [7:0]   ch;
        case (msg)
            2'd0:    row = line2 ? TXT_S_L2 : TXT_S_L1;
            2'd1:    row = line2 ? TXT_F_L2 : TXT_F_L1;
            2'd2:    row = line2 ? TXT_R_L2 : TXT_R_L1;
            default: row = line2 ? TXT_L_L2 : TXT_L_L1;
        endcase
        row_sh = row << {col, 3'b000};
        ch     = row_sh[127:120];
        if (msg == 2'd3 && !line2 && col == 4'd10) begin
            ch = (lvl < 4'd10) ? (8'h30 + {4'b0000, lvl}) : (8'h37 + {4'b0000, lvl});
        end
        return ch;
    endfunction

    // State, counters and latched request; reset aborts any message in progress.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q     <= S_IDLE;
            cnt_q       <= 32'd0;
            idx_q       <= 5'd0;
            start_q     <= 1'b0;
            init_done_q <= 1'b0;
            msg_q       <= 2'd0;
            lvl_q       <= 4'd0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            start_q     <= START;
            init_done_q <= init_done_d;
            msg_q       <= msg_d;
            lvl_q       <= lvl_d;
            pass_q      <= pass_d;
        end
    end

    // Next-state, slot timing and LCD bus decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 32'd1;
        idx_d       = idx_q;
        init_done_d = init_done_q;
        msg_d       = msg_q;
        lvl_d       = lvl_q;
        pass_d      = pass_q;
        cmd         = 1'b0;
        rs_c        = 1'b0;
        data_c      = 8'h00;
        e_c         = 1'b0;
        done_c      = 1'b0;
        slot_end    = (state_q == S_CLEAR || state_q == S_END_CLR) ? (cnt_q == CLR_LAST)
                                                                    : (cnt_q == SLOT_LAST);

        case (state_q)
            S_IDLE: begin
                cnt_d = 32'd0;
                if (START && !start_q) begin
                    msg_d   = MSG_SEL;
                    lvl_d   = LEVEL;
                    state_d = init_done_q ? S_CLEAR : S_FUNC;
                end
            end
            S_FUNC: begin
                cmd    = 1'b1;
                data_c = 8'h38;
                if (slot_end) state_d = S_DISP;
            end
            S_DISP: begin
                cmd    = 1'b1;
                data_c = 8'h0C;
                if (slot_end) state_d = S_ENTRY;
            end
            S_ENTRY: begin
                cmd    = 1'b1;
                data_c = 8'h06;
                if (slot_end) begin
                    state_d     = S_CLEAR;
                    init_done_d = 1'b1;
                end
            end
            S_CLEAR: begin
                cmd    = 1'b1;
                data_c = 8'h01;
                if (slot_end) state_d = S_L1_ADDR;
            end
            S_L1_ADDR: begin
                cmd    = 1'b1;
                data_c = 8'h80;
                idx_d  = 5'd0;
                if (slot_end) state_d = S_L1_CHAR;
            end
            S_L1_CHAR: begin
                cmd    = 1'b1;
                rs_c   = 1'b1;
                data_c = msg_char(msg_q, 1'b0, idx_q[3:0], lvl_q);
                if (slot_end) begin
                    if (idx_q == 5'd15) state_d = S_L2_ADDR;
                    else                idx_d   = idx_q + 5'd1;
                end
            end
            S_L2_ADDR: begin
                cmd    = 1'b1;
                data_c = 8'hC0;
                idx_d  = 5'd0;
                if (slot_end) state_d = S_L2_CHAR;
            end
            S_L2_CHAR: begin
                cmd    = 1'b1;
                rs_c   = 1'b1;
                data_c = msg_char(msg_q, 1'b1, idx_q[3:0], lvl_q);
                if (slot_end) begin
                    if (idx_q == 5'd15) state_d = S_HOLD;
                    else                idx_d   = idx_q + 5'd1;
                end
            end
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d = 32'd0;
`ifdef LCD_AUTO_CLEAR_EN
                    state_d = S_END_CLR;
`else
                    state_d = S_FIN;
                    pass_d  = (msg_q == 2'd0);
`endif
                end
            end
            S_END_CLR: begin
                cmd    = 1'b1;
                data_c = 8'h01;
                if (slot_end) begin
                    state_d = S_FIN;
                    pass_d  = (msg_q == 2'd0);
                end
            end
            S_FIN: begin
                done_c  = 1'b1;
                cnt_d   = 32'd0;
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = 32'd0;
                state_d = S_IDLE;
            end
        endcase

        if (cmd) begin
            e_c = (cnt_q >= 32'd1) && (cnt_q <= 32'(E_PULSE));
            if (slot_end) cnt_d = 32'd0;
        end
    end

    assign TLCD_RS   = rs_c;
    assign TLCD_RW   = 1'b0;
    assign TLCD_E    = e_c;
    assign TLCD_DATA = data_c;
    assign BUSY      = (state_q != S_IDLE);
    assign DONE      = done_c;
    assign PASS      = pass_q;

endmodule

// File: tb/tb_lcd_msg_ctrl.sv
// Self-checking bench for lcd_msg_ctrl: expected LCD bytes are queued per request and popped on each E rising edge.
// Latency: checks BUSY length, DONE pulse count, PASS, E width and abort-on-reset behaviour.
// Backpressure: not applicable; START edges during BUSY are exercised and must be ignored.
module tb_lcd_msg_ctrl;

    logic       CLK = 1'b0;
    logic       RESETN;
    logic       START;
    logic [1:0] MSG_SEL;
    logic [3:0] LEVEL;
    logic       TLCD_RS;
    logic       TLCD_RW;
    logic       TLCD_E;
    logic [7:0] TLCD_DATA;
    logic       BUSY;
    logic       DONE;
    logic       PASS;

    always #5 CLK = ~CLK;

`ifdef LCD_AUTO_CLEAR_EN
    localparam int BUSY_INIT   = 1160;
    localparam int BUSY_NOINIT = 1148;
`else
    localparam int BUSY_INIT   = 1154;
    localparam int BUSY_NOINIT = 1142;
`endif

    lcd_msg_ctrl #(
        .CLK_HZ  (1_000_000),
        .E_PULSE (1),
        .EXEC_US (2),
        .CLEAR_US(4),
        .HOLD_MS (1)
    ) dut (
        .CLK      (CLK),
        .RESETN   (RESETN),
        .START    (START),
        .MSG_SEL  (MSG_SEL),
        .LEVEL    (LEVEL),
        .TLCD_RS  (TLCD_RS),
        .TLCD_RW  (TLCD_RW),
        .TLCD_E   (TLCD_E),
        .TLCD_DATA(TLCD_DATA),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .PASS     (PASS)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [8:0] exp_q[$];
    int         busy_cnt = 0;
    int         done_cnt = 0;
    int         e_run    = 0;
    logic       e_prev   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock cycle; samples DUT outputs on the falling edge and scores the bus.
    task automatic step();
        logic [8:0] v;
        @(negedge CLK);
        if (BUSY) busy_cnt++;
        if (DONE) begin
            done_cnt++;
            check("busy_at_done", 32'(BUSY), 32'd1);
        end
        if (TLCD_E && !e_prev) begin
            if (exp_q.size() == 0) begin
                check("extra_byte", 32'(exp_q.size()), 32'd1);
            end else begin
                v = exp_q.pop_front();
                check("bus_byte", 32'({TLCD_RS, TLCD_DATA}), 32'(v));
            end
            check("rw_low", 32'(TLCD_RW), 32'd0);
        end
        if (!TLCD_E && e_prev) check("e_width", 32'(e_run), 32'd1);
        e_run  = TLCD_E ? e_run + 1 : 0;
        e_prev = TLCD_E;
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, s[i]});
    endtask

    task automatic push_msg(input logic [1:0] sel, input logic [3:0] lv, input bit init);
        string l1;
        string l2;
        byte   dg;
        if (init) begin
            exp_q.push_back(9'h038);
            exp_q.push_back(9'h00C);
            exp_q.push_back(9'h006);
        end
        exp_q.push_back(9'h001);
        case (sel)
            2'd0: begin l1 = "    SUCCESS     "; l2 = "    GOOD JOB    "; end
            2'd1: begin l1 = "      FAIL      "; l2 = "   TRY AGAIN    "; end
            2'd2: begin l1 = "     READY      "; l2 = "  PRESS START   "; end
            default: begin
                l1 = "    LEVEL       ";
                l2 = "   KEEP GOING   ";
                dg = (lv < 4'd10) ? byte'(8'h30 + {4'b0000, lv}) : byte'(8'h41 + {4'b0000, lv} - 8'd10);
                l1.putc(10, dg);
            end
        endcase
        exp_q.push_back(9'h080);
        push_str(l1);
        exp_q.push_back(9'h0C0);
        push_str(l2);
`ifdef LCD_AUTO_CLEAR_EN
        exp_q.push_back(9'h001);
`endif
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (done_cnt == 0 && k < 3000) begin
            step();
            k++;
        end
    endtask

    task automatic end_checks(input string tag, input int exp_busy, input logic exp_pass);
        step();
        START = 1'b0;
        repeat (4) step();
        check({tag, "_busy_len"}, 32'(busy_cnt), 32'(exp_busy));
        check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        check({tag, "_pass"}, 32'(PASS), 32'(exp_pass));
        check({tag, "_idle"}, 32'(BUSY), 32'd0);
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_msg(input string tag, input logic [1:0] sel, input logic [3:0] lv,
                           input bit init, input int exp_busy, input logic exp_pass);
        push_msg(sel, lv, init);
        busy_cnt = 0;
        done_cnt = 0;
        MSG_SEL  = sel;
        LEVEL    = lv;
        START    = 1'b1;
        wait_done();
        end_checks(tag, exp_busy, exp_pass);
    endtask

    initial begin
        RESETN  = 1'b0;
        START   = 1'b0;
        MSG_SEL = 2'd0;
        LEVEL   = 4'd0;
        repeat (3) step();
        check("rst_e", 32'(TLCD_E), 32'd0);
        check("rst_rs", 32'(TLCD_RS), 32'd0);
        check("rst_data", 32'(TLCD_DATA), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_done", 32'(DONE), 32'd0);
        check("rst_pass", 32'(PASS), 32'd0);
        RESETN = 1'b1;
        repeat (2) step();

        run_msg("success_init", 2'd0, 4'd0, 1'b1, BUSY_INIT, 1'b1);
        run_msg("fail_msg", 2'd1, 4'd0, 1'b0, BUSY_NOINIT, 1'b0);
        run_msg("level7", 2'd3, 4'd7, 1'b0, BUSY_NOINIT, 1'b0);
        run_msg("level12", 2'd3, 4'd12, 1'b0, BUSY_NOINIT, 1'b0);

        // START toggled and MSG_SEL changed while a READY message is being written.
        push_msg(2'd2, 4'd0, 1'b0);
        busy_cnt = 0;
        done_cnt = 0;
        MSG_SEL  = 2'd2;
        START    = 1'b1;
        repeat (3) step();
        START = 1'b0;
        step();
        START = 1'b1;
        step();
        START = 1'b0;
        repeat (2) step();
        START = 1'b1;
        repeat (25) step();
        MSG_SEL = 2'd0;
        LEVEL   = 4'd9;
        repeat (5) step();
        START = 1'b0;
        wait_done();
        end_checks("toggle", BUSY_NOINIT, 1'b0);
        repeat (10) step();
        check("toggle_no_restart", 32'(BUSY), 32'd0);
        check("toggle_single_done", 32'(done_cnt), 32'd1);

        run_msg("success_again", 2'd0, 4'd0, 1'b0, BUSY_NOINIT, 1'b1);

        // Reset asserted asynchronously while line 1 characters are going out.
        push_msg(2'd1, 4'd0, 1'b0);
        MSG_SEL = 2'd1;
        START   = 1'b1;
        repeat (30) step();
        check("pre_abort_busy", 32'(BUSY), 32'd1);
        #2;
        RESETN = 1'b0;
        #1;
        check("abort_e", 32'(TLCD_E), 32'd0);
        check("abort_rs", 32'(TLCD_RS), 32'd0);
        check("abort_data", 32'(TLCD_DATA), 32'd0);
        check("abort_busy", 32'(BUSY), 32'd0);
        check("abort_pass", 32'(PASS), 32'd0);
        exp_q.delete();
        START = 1'b0;
        repeat (3) step();
        RESETN = 1'b1;
        repeat (2) step();
        check("post_abort_idle", 32'(BUSY), 32'd0);

        run_msg("fail_reinit", 2'd1, 4'd0, 1'b1, BUSY_INIT, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
